// File: rtl/skew_pkg.sv
// Shared types and delay helpers for the per-lane skew buffer.
// Used by skew_lane and skew_buf.
package skew_pkg;

  typedef enum logic {
    SKEW_FWD,
    SKEW_REV
  } skew_mode_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } skew_state_e;

  function automatic int lane_delay(
    skew_mode_e mode,
    int base,
    int dim,
    int i
  );
    return (mode == SKEW_FWD) ? base + i : base + dim - 1 - i;
  endfunction

  function automatic int max_delay(int base, int dim);
    return base + dim - 1;
  endfunction

endpackage

// File: rtl/skew_lane.sv
// One lane of the skew buffer: a DEPTH-stage {valid,data} shift chain.
// Stage 0 takes the fill word; the last stage is the lane output.
module skew_lane #(
  parameter int DEPTH = 1,
  parameter int BITS  = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            shift_i,
  input  logic            fill_valid_i,
  input  logic [BITS-1:0] fill_data_i,
  output logic            out_valid_o,
  output logic [BITS-1:0] out_data_o,
  output logic            any_q_o,
  output logic            any_d_o
);

  logic [DEPTH-1:0]           valid_q, valid_d;
  logic [DEPTH-1:0][BITS-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (shift_i) begin
      valid_d[0] = fill_valid_i;
      data_d[0]  = fill_data_i;
      for (int s = 1; s < DEPTH; s++) begin
        valid_d[s] = valid_q[s-1];
        data_d[s]  = data_q[s-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid_o = valid_q[DEPTH-1];
  assign out_data_o  = data_q[DEPTH-1];
  assign any_q_o     = |valid_q;
  assign any_d_o     = |valid_d;

endmodule

// File: rtl/skew_buf.sv
// Per-lane skew/de-skew delay buffer with a drain FSM.
// SKEW_BUF_ZERO_FILL_EN masks Bout to 0 on lanes whose valid is low.
module skew_buf
  import skew_pkg::*;
#(
  parameter int         BITS_AB = 8,
  parameter int         DIM     = 8,
  parameter int         BASE    = DIM,
  parameter skew_mode_e MODE    = SKEW_FWD
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        in_valid,
  input  logic [DIM-1:0][BITS_AB-1:0] Bin,
  input  logic                        drain,
  output logic                        in_ready,
  output logic [DIM-1:0][BITS_AB-1:0] Bout,
  output logic [DIM-1:0]              Bout_valid,
  output logic                        busy,
  output logic                        drain_done
);

  localparam int MAXD = max_delay(BASE, DIM);
  localparam int CW   = $clog2(MAXD + 1);

  skew_state_e                 state_q, state_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic                        done_q, done_d;
  logic                        shift;
  logic                        fill_v;
  logic [DIM-1:0]              any_q, any_d;
  logic [DIM-1:0][BITS_AB-1:0] last_data;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    shift   = 1'b0;
    fill_v  = 1'b0;
    unique case (state_q)
      IDLE, RUN: begin
        shift  = en;
        fill_v = in_valid;
        if (drain) begin
          // Nothing in flight and nothing arriving: acknowledge at once.
          if (state_q == IDLE && !(en && in_valid)) begin
            shift  = 1'b0;
            done_d = 1'b1;
          end else begin
            state_d = DRAIN;
            cnt_d   = CW'(MAXD);
          end
        end else if (shift) begin
          state_d = (|any_d) ? RUN : IDLE;
        end
      end
      DRAIN: begin
        shift = 1'b1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  for (genvar i = 0; i < DIM; i++) begin : g_lane
    localparam int D = lane_delay(MODE, BASE, DIM, i);
    logic [BITS_AB-1:0] fill_data;

    assign fill_data = (state_q == DRAIN) ? '0 : Bin[i];

    skew_lane #(
      .DEPTH(D),
      .BITS (BITS_AB)
    ) u_lane (
      .clk         (clk),
      .rst_n       (rst_n),
      .shift_i     (shift),
      .fill_valid_i(fill_v),
      .fill_data_i (fill_data),
      .out_valid_o (Bout_valid[i]),
      .out_data_o  (last_data[i]),
      .any_q_o     (any_q[i]),
      .any_d_o     (any_d[i])
    );

`ifdef SKEW_BUF_ZERO_FILL_EN
    assign Bout[i] = Bout_valid[i] ? last_data[i] : '0;
`else
    assign Bout[i] = last_data[i];
`endif
  end

  assign in_ready   = (state_q != DRAIN);
  assign busy       = (|any_q) || (state_q == DRAIN);
  assign drain_done = done_q;

endmodule
